// File: rtl/sram_sched_pkg.sv
// Shared types, command field bounds and the round-robin picker for the SRAM scheduler.
package sram_sched_pkg;

    typedef enum logic [1:0] {
        REQ_W0 = 2'd0,
        REQ_W1 = 2'd1,
        REQ_R0 = 2'd2,
        REQ_R1 = 2'd3
    } req_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } sched_state_e;

    localparam int MASK_HI = 53;
    localparam int MASK_LO = 50;
    localparam int ADDR_HI = 49;
    localparam int ADDR_LO = 32;
    localparam int DATA_HI = 31;
    localparam int DATA_LO = 0;

    localparam int CMD_W   = 54;
    localparam int ADDR_W  = 18;
    localparam int DATA_W  = 32;
    localparam int MASK_W  = 4;
    localparam int TAG_W   = 1;
    localparam int STAT_W  = 16;

    // Scan W0,W1,R0,R1 cyclically, starting just after the previous winner.
    function automatic req_e rr_pick(input logic [3:0] elig, input req_e last);
        req_e       pick;
        logic [1:0] idx;
        logic       found;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = 2'(int'(last) + i);
            if (!found && elig[idx]) begin
                pick  = req_e'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/sram_tag_fifo.sv
// Synchronous FIFO of read-requester tags; tracks which reader owns each in-flight SRAM read.
module sram_tag_fifo
    import sram_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic [TAG_W-1:0]          din,
    input  logic                      pop,
    output logic [TAG_W-1:0]          dout,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      empty
);

    localparam int AW = $clog2(DEPTH);

    logic [TAG_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees a slot, so a full FIFO still takes the push.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_rr_scheduler.sv
// Round-robin SRAM command scheduler for two write and two read requesters.
// Optional per-requester grant counters are built when SRAM_SCHED_STATS_EN is defined.
module sram_rr_scheduler
    import sram_sched_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                sram_clock,
    input  logic                reset,
    input  logic                w0_valid,
    input  logic [CMD_W-1:0]    w0_din,
    output logic                w0_rd_en,
    input  logic                w1_valid,
    input  logic [CMD_W-1:0]    w1_din,
    output logic                w1_rd_en,
    input  logic                r0_valid,
    input  logic [ADDR_W-1:0]   r0_addr,
    output logic                r0_rd_en,
    input  logic                r1_valid,
    input  logic [ADDR_W-1:0]   r1_addr,
    output logic                r1_rd_en,
    input  logic                r0_space_ok,
    input  logic                r1_space_ok,
    input  logic                sram_ready,
    output logic                sram_addr_valid,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic [DATA_W-1:0]   sram_data_in,
    output logic [MASK_W-1:0]   sram_write_mask,
    input  logic                sram_data_out_valid,
    output logic                r0_data_wr_en,
    output logic                r1_data_wr_en,
    output logic                fsm_state,
    output logic                err_unexpected_return
`ifdef SRAM_SCHED_STATS_EN
    ,
    output logic [STAT_W-1:0]   grant_cnt_w0,
    output logic [STAT_W-1:0]   grant_cnt_w1,
    output logic [STAT_W-1:0]   grant_cnt_r0,
    output logic [STAT_W-1:0]   grant_cnt_r1
`endif
);

    localparam int AW = $clog2(MAX_OUTSTANDING);

    // Handshake: a command is accepted in an ISSUE cycle where sram_ready=1; the
    // matching rd_en pulses in that same cycle and nothing is popped otherwise.
    sched_state_e state, state_nxt;
    req_e         grant, grant_nxt;
    req_e         last_grant, last_grant_nxt;
    logic [3:0]   elig;
    logic         read_ok;
    logic         accept;
    logic         is_read;
    logic         tag_push;
    logic         tag_pop;
    logic         tag_dout;
    logic         tag_full;
    logic         tag_empty;
    logic [AW:0]  outstanding;
    logic         err_flag;

    assign read_ok = (outstanding < (AW+1)'(MAX_OUTSTANDING));
    assign elig    = {r1_valid && r1_space_ok && read_ok,
                      r0_valid && r0_space_ok && read_ok,
                      w1_valid,
                      w0_valid};
    assign accept  = (state == ST_ISSUE) && sram_ready && !reset;
    assign is_read = (grant == REQ_R0) || (grant == REQ_R1);

    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        case (state)
            ST_IDLE: begin
                if (|elig) begin
                    grant_nxt = rr_pick(elig, last_grant);
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (sram_ready) begin
                    last_grant_nxt = grant;
                    state_nxt      = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sram_clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            grant      <= REQ_W0;
            last_grant <= REQ_R1;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    // Command fields come straight from the granted FIFO head; reset forces everything low.
    always_comb begin
        sram_addr_valid = 1'b0;
        sram_addr       = '0;
        sram_data_in    = '0;
        sram_write_mask = '0;
        w0_rd_en        = 1'b0;
        w1_rd_en        = 1'b0;
        r0_rd_en        = 1'b0;
        r1_rd_en        = 1'b0;
        if ((state == ST_ISSUE) && !reset) begin
            sram_addr_valid = 1'b1;
            case (grant)
                REQ_W0: begin
                    sram_addr       = w0_din[ADDR_HI:ADDR_LO];
                    sram_data_in    = w0_din[DATA_HI:DATA_LO];
                    sram_write_mask = w0_din[MASK_HI:MASK_LO];
                    w0_rd_en        = sram_ready;
                end
                REQ_W1: begin
                    sram_addr       = w1_din[ADDR_HI:ADDR_LO];
                    sram_data_in    = w1_din[DATA_HI:DATA_LO];
                    sram_write_mask = w1_din[MASK_HI:MASK_LO];
                    w1_rd_en        = sram_ready;
                end
                REQ_R0: begin
                    sram_addr = r0_addr;
                    r0_rd_en  = sram_ready;
                end
                REQ_R1: begin
                    sram_addr = r1_addr;
                    r1_rd_en  = sram_ready;
                end
                default: begin
                    sram_addr_valid = 1'b0;
                end
            endcase
        end
    end

    assign tag_push = accept && is_read && !tag_full;
    assign tag_pop  = sram_data_out_valid && !reset;

    sram_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk   (sram_clock),
        .reset (reset),
        .push  (tag_push),
        .din   (grant == REQ_R1),
        .pop   (tag_pop),
        .dout  (tag_dout),
        .count (outstanding),
        .full  (tag_full),
        .empty (tag_empty)
    );

    assign r0_data_wr_en = tag_pop && !tag_empty && !tag_dout;
    assign r1_data_wr_en = tag_pop && !tag_empty &&  tag_dout;

    // Returned data with no matching tag is dropped; the flag stays up until reset.
    always_ff @(posedge sram_clock) begin
        if (reset) begin
            err_flag <= 1'b0;
        end else if (sram_data_out_valid && tag_empty) begin
            err_flag <= 1'b1;
        end
    end

    assign err_unexpected_return = err_flag && !reset;
    assign fsm_state             = reset ? 1'b0 : state;

`ifdef SRAM_SCHED_STATS_EN
    logic [3:0][STAT_W-1:0] grant_cnt;

    always_ff @(posedge sram_clock) begin
        if (reset) begin
            grant_cnt <= '0;
        end else if (accept && (grant_cnt[grant] != '1)) begin
            grant_cnt[grant] <= grant_cnt[grant] + 1'b1;
        end
    end

    assign grant_cnt_w0 = reset ? '0 : grant_cnt[REQ_W0];
    assign grant_cnt_w1 = reset ? '0 : grant_cnt[REQ_W1];
    assign grant_cnt_r0 = reset ? '0 : grant_cnt[REQ_R0];
    assign grant_cnt_r1 = reset ? '0 : grant_cnt[REQ_R1];
`endif

endmodule

// File: doc/sram_rr_scheduler.md
SRAM_RR_SCHEDULER -- requirements
Module: sram_rr_scheduler

Interface
REQ-001 Parameter: MAX_OUTSTANDING, default 4, maximum number of reads issued to SRAM and not yet returned (power of two, 2..16).
REQ-002 The block SHALL use one clock and a synchronous, active-high reset, with ports as below.
- sram_clock  in  1  sole clock
- reset  in  1  synchronous, active-high
- w0_valid, w1_valid  in  1  write FIFO head valid (FWFT)
- w0_din, w1_din  in  54  {mask[53:50], addr[49:32], data[31:0]}
- w0_rd_en, w1_rd_en  out  1  pop write FIFO
- r0_valid, r1_valid  in  1  read-address FIFO head valid (FWFT)
- r0_addr, r1_addr  in  18  read address
- r0_rd_en, r1_rd_en  out  1  pop read-address FIFO
- r0_space_ok, r1_space_ok  in  1  return-data FIFO not prog_full
- sram_ready  in  1  SRAM accepts a command this cycle
- sram_addr_valid  out  1  command valid
- sram_addr  out  18; sram_data_in  out  32; sram_write_mask  out  4
- sram_data_out_valid  in  1  read data returned this cycle
- r0_data_wr_en, r1_data_wr_en  out  1  push returned data to r0/r1 data FIFO
- err_unexpected_return  out  1  sticky error flag

Function
REQ-003 FSM SHALL have two states: IDLE and ISSUE.
REQ-004 Eligibility: a writer is eligible when wN_valid=1. A reader is eligible when rN_valid=1, rN_space_ok=1 and outstanding < MAX_OUTSTANDING.
REQ-005 IDLE: if any requester is eligible, the block SHALL register the grant and go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-006 Grant SHALL be round-robin in the fixed order W0,W1,R0,R1, starting after last_grant.
REQ-007 ISSUE: sram_addr_valid=1 and the address, data and mask are driven combinationally from the granted head. The mask is 4'b0000 for reads. sram_data_in=0 for reads.
REQ-008 Accept occurs in an ISSUE cycle with sram_ready=1. On accept, the granted rd_en SHALL pulse for exactly that cycle, last_grant SHALL update, and the next state SHALL be IDLE. This gives one command per two cycles at best.
REQ-009 In ISSUE with sram_ready=0, all outputs SHALL hold and no pop SHALL occur. The grant SHALL NOT change even if the head's valid or space_ok drops.
REQ-010 An accepted read SHALL push its requester ID (0=R0, 1=R1) into the tag FIFO and increment outstanding.
REQ-011 sram_data_out_valid=1 with a non-empty tag FIFO SHALL pop the head tag and pulse r0_data_wr_en or r1_data_wr_en in the same cycle. Return order equals issue order.
REQ-012 sram_data_out_valid=1 with an empty tag FIFO SHALL drop the data (no wr_en) and set err_unexpected_return.
REQ-013 A tag push and pop in the same cycle SHALL leave outstanding unchanged and preserve FIFO order.
REQ-014 When outstanding = MAX_OUTSTANDING, reads SHALL be ineligible; writes SHALL remain eligible.
REQ-015 At most one rd_en and at most one data_wr_en SHALL be asserted per cycle.

Reset
REQ-016 When reset is asserted, the block SHALL enter IDLE and set last_grant=R1, so that W0 has first priority.
REQ-017 Reset SHALL clear the tag FIFO, outstanding and err_unexpected_return.
REQ-018 While reset is asserted, all outputs SHALL be 0.
REQ-019 Reset asserted mid-ISSUE SHALL abandon the command with no pop, and SHALL discard tags for in-flight reads.

Configuration
REQ-020 Macro SRAM_SCHED_STATS_EN: when defined, the block SHALL add outputs grant_cnt_w0, grant_cnt_w1, grant_cnt_r0 and grant_cnt_r1 (16-bit each). Each counter increments on an accepted grant to that requester, saturates at 16'hFFFF, and resets to 0.
REQ-021 Without SRAM_SCHED_STATS_EN, these ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-022 Package sram_sched_pkg SHALL hold:
- the requester encoding (W0=0, W1=1, R0=2, R1=3);
- the command field bounds (MASK_HI=53, MASK_LO=50, ADDR_HI=49, ADDR_LO=32, DATA_HI=31, DATA_LO=0);
- the tag width.
REQ-023 The tag FIFO SHALL be one sub-module, sram_tag_fifo: synchronous, depth MAX_OUTSTANDING, 1-bit data, with count output, full/empty flags and simultaneous push/pop support.

Verification
REQ-024 All four requesters valid continuously, sram_ready=1, space_ok=1, reads returned 1 cycle after issue -> grant order W0,W1,R0,R1,W0,..., one accept every 2 cycles.
REQ-025 Only R0 valid, MAX_OUTSTANDING=4, no returns -> exactly 4 r0_rd_en pulses. Then one return -> one r0_data_wr_en, followed by a fifth issue.
REQ-026 Issue R1 then R0 (addr 18'h00010, 18'h00020), data returned as 32'hAAAA0001 then 32'hBBBB0002 -> r1_data_wr_en first, then r0_data_wr_en.
REQ-027 W0 granted with w0_din={4'b1010,18'h3FFFF,32'hDEADBEEF}, sram_ready=0 for 3 cycles -> sram_addr=18'h3FFFF, mask=4'b1010 held; w0_rd_en pulses once in the cycle sram_ready=1.
REQ-028 sram_data_out_valid=1 with no outstanding reads -> no data_wr_en, err_unexpected_return=1 until reset. Reset asserted during ISSUE -> next cycle IDLE, all outputs 0.
